// File: rtl/rr_arb_pkg.sv
// Shared types, constants and helpers for the four-requester round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 4;

    // Two-state controller encoding, kept as plain constants so legacy
    // tooling that does not understand enums can still read the state.
    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    // Pointer to the requester that follows 'id' in circular order.
    function automatic logic [1:0] next_ptr(input logic [1:0] id);
        return 2'((int'(id) + 1) % N_REQ);
    endfunction

endpackage

// File: rtl/rr_arb_4_if.sv
// Requester/resource-side bundle of the round-robin arbiter.
interface rr_arb_4_if;
    import rr_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       gnt_id;
    logic             busy;
    logic             timeout;

    // Requester/test side drives requests and release, observes the grant.
    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    // Arbiter side consumes requests and produces the grant.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );

endinterface

// File: rtl/deco_2x4.sv
// Plain 2-to-4 one-hot decoder.
module deco_2x4 (
    input  logic [1:0] sel,
    output logic [3:0] y
);

    // Shift a single one into the selected position.
    always_comb begin
        y = 4'b0001 << sel;
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set request at or after ptr.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             valid,
    output logic [1:0]       win_id
);

    // Scan ptr, ptr+1, ... with 2-bit wraparound and keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        valid  = 1'b0;
        win_id = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [1:0] idx;
            idx = ptr + 2'(i);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                win_id = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter with release-on-done, release-on-drop
// and an optional hold timeout. CNT_W must satisfy 2**CNT_W > MAX_HOLD.
module rr_arb_4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    rr_arb_4_if.slave  bus
);

    state_t             state;
    logic [1:0]         ptr;
    logic [CNT_W-1:0]   hold_cnt;
    logic [1:0]         gnt_id;
    logic               busy;
    logic               timeout;

    logic               pick_valid;
    logic [1:0]         pick_id;
    logic [N_REQ-1:0]   dec_id;

    logic               normal_rel;
    logic               forced_rel;

    rr_pick u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .win_id (pick_id)
    );

    deco_2x4 u_deco (
        .sel (gnt_id),
        .y   (dec_id)
    );

    // Release conditions for the current owner, evaluated while granted.
    always_comb begin
        normal_rel = bus.done || !bus.req[gnt_id];
        forced_rel = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));
    end

    // Grant controller: pick in IDLE, hold/release in GRANT.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            gnt_id   <= 2'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= GRANT;
                        busy     <= 1'b1;
                        gnt_id   <= pick_id;
                        hold_cnt <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (normal_rel || forced_rel) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        ptr      <= next_ptr(gnt_id);
                        // A simultaneous normal release wins: no pulse.
                        timeout  <= forced_rel && !normal_rel;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Grant vector is the decoded owner, forced to zero when idle.
    always_comb begin
        bus.gnt = dec_id & {N_REQ{busy}};
    end

    assign bus.gnt_id  = gnt_id;
    assign bus.busy    = busy;
    assign bus.timeout = timeout;

endmodule

// File: tb/tb_rr_arb_4.sv
// Directed self-checking bench for rr_arb_4 (default, MAX_HOLD=4, MAX_HOLD=0).
module tb_rr_arb_4;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    rr_arb_4_if i_def ();
    rr_arb_4_if i_h4  ();
    rr_arb_4_if i_h0  ();

    rr_arb_4 #(.MAX_HOLD(16), .CNT_W(5)) dut    (.clk(clk), .rst(rst), .bus(i_def));
    rr_arb_4 #(.MAX_HOLD(4),  .CNT_W(5)) dut_h4 (.clk(clk), .rst(rst), .bus(i_h4));
    rr_arb_4 #(.MAX_HOLD(0),  .CNT_W(5)) dut_h0 (.clk(clk), .rst(rst), .bus(i_h0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_run++;
        if (i_def.gnt !== 4'b0000 || i_def.busy !== 1'b0 || i_def.timeout !== 1'b0 || i_def.gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b id=%0d busy=%b to=%b, need 0000/0/0/0",
                     i_def.gnt, i_def.gnt_id, i_def.busy, i_def.timeout);
        end
        n_run++;
        if (i_h4.gnt !== 4'b0000 || i_h0.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_other: h4=%b h0=%b, need 0000", i_h4.gnt, i_h0.gnt);
        end
    endtask

    // Single requester 2, release via done, then ptr=3 shows in next pick.
    task automatic test_single_done();
        i_def.req = 4'b0100;
        step();
        n_run++;
        if (i_def.gnt !== 4'b0100 || i_def.gnt_id !== 2'd2 || i_def.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b id=%0d busy=%b, need 0100/2/1",
                     i_def.gnt, i_def.gnt_id, i_def.busy);
        end
        step();
        step();
        i_def.done = 1'b1;
        i_def.req  = 4'b0000;
        step();
        i_def.done = 1'b0;
        n_run++;
        if (i_def.gnt !== 4'b0000 || i_def.busy !== 1'b0 || i_def.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: gnt=%b busy=%b to=%b, need 0000/0/0",
                     i_def.gnt, i_def.busy, i_def.timeout);
        end
        i_def.req = 4'b1111;
        step();
        n_run++;
        if (i_def.gnt !== 4'b1000 || i_def.gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL ptr_after_2: gnt=%b id=%0d, need 1000/3", i_def.gnt, i_def.gnt_id);
        end
    endtask

    // All four requesting, done after 2 cycles: order 0,1,2,3,0 with gaps.
    task automatic test_fairness();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        i_def.done = 1'b1;
        step();
        i_def.done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_run++;
            if (i_def.gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL fair_gap%0d: gnt=%b, need 0000", k, i_def.gnt);
            end
            step();
            n_run++;
            if (i_def.gnt !== exp_seq[k] || i_def.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL fair_grant%0d: gnt=%b busy=%b, need %b/1",
                         k, i_def.gnt, i_def.busy, exp_seq[k]);
            end
            step();
            n_run++;
            if (i_def.gnt !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL fair_hold%0d: gnt=%b, need %b", k, i_def.gnt, exp_seq[k]);
            end
            i_def.done = 1'b1;
            step();
            i_def.done = 1'b0;
        end
        i_def.req = 4'b0000;
        step();
    endtask

    // Owner 1 drops its request with 0 and 3 pending: next owner is 3.
    task automatic test_drop();
        i_def.req = 4'b0010;
        step();
        n_run++;
        if (i_def.gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_grant: gnt=%b, need 0010", i_def.gnt);
        end
        step();
        i_def.req = 4'b1001;
        step();
        n_run++;
        if (i_def.gnt !== 4'b0000 || i_def.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_release: gnt=%b to=%b, need 0000/0", i_def.gnt, i_def.timeout);
        end
        step();
        n_run++;
        if (i_def.gnt !== 4'b1000 || i_def.gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL drop_next: gnt=%b id=%0d, need 1000/3", i_def.gnt, i_def.gnt_id);
        end
    endtask

    // Reset while owner 3 holds: grant drops, no pulse, ptr restarts at 0.
    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        n_run++;
        if (i_def.gnt !== 4'b0000 || i_def.busy !== 1'b0 || i_def.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: gnt=%b busy=%b to=%b, need 0000/0/0",
                     i_def.gnt, i_def.busy, i_def.timeout);
        end
        rst = 1'b0;
        step();
        n_run++;
        if (i_def.gnt !== 4'b0001 || i_def.gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_regrant: gnt=%b id=%0d, need 0001/0", i_def.gnt, i_def.gnt_id);
        end
        i_def.req = 4'b0000;
        step();
    endtask

    // done while idle with no requests must not create a grant.
    task automatic test_idle_done();
        i_def.done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_run++;
            if (i_def.gnt !== 4'b0000 || i_def.busy !== 1'b0 || i_def.timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_done%0d: gnt=%b busy=%b to=%b, need 0000/0/0",
                         c, i_def.gnt, i_def.busy, i_def.timeout);
            end
        end
        i_def.done = 1'b0;
    endtask

    // MAX_HOLD=4: four grant cycles, one timeout cycle, regrant; then a
    // done coinciding with the limit suppresses the pulse.
    task automatic test_timeout();
        i_h4.req = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_run++;
            if (i_h4.gnt !== 4'b0010 || i_h4.timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL to_hold%0d: gnt=%b to=%b, need 0010/0", c, i_h4.gnt, i_h4.timeout);
            end
        end
        step();
        n_run++;
        if (i_h4.gnt !== 4'b0000 || i_h4.timeout !== 1'b1 || i_h4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_pulse: gnt=%b to=%b busy=%b, need 0000/1/0",
                     i_h4.gnt, i_h4.timeout, i_h4.busy);
        end
        step();
        n_run++;
        if (i_h4.gnt !== 4'b0010 || i_h4.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_regrant: gnt=%b to=%b, need 0010/0", i_h4.gnt, i_h4.timeout);
        end
        step();
        step();
        step();
        i_h4.done = 1'b1;
        step();
        i_h4.done = 1'b0;
        i_h4.req  = 4'b0000;
        n_run++;
        if (i_h4.gnt !== 4'b0000 || i_h4.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_coincide: gnt=%b to=%b, need 0000/0", i_h4.gnt, i_h4.timeout);
        end
        step();
    endtask

    // MAX_HOLD=0: grant held 40 cycles with no timeout.
    task automatic test_no_timeout();
        int bad;
        bad = 0;
        i_h0.req = 4'b0100;
        for (int c = 0; c < 40; c++) begin
            step();
            n_run++;
            if (i_h0.gnt !== 4'b0100 || i_h0.timeout !== 1'b0) begin
                n_fail++;
                bad++;
                if (bad < 4)
                    $display("FAIL no_to%0d: gnt=%b to=%b, need 0100/0", c, i_h0.gnt, i_h0.timeout);
            end
        end
        i_h0.req = 4'b0000;
        step();
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        i_def.req = 4'b0000; i_def.done = 1'b0;
        i_h4.req  = 4'b0000; i_h4.done  = 1'b0;
        i_h0.req  = 4'b0000; i_h0.done  = 1'b0;
        test_reset();
        test_single_done();
        test_fairness();
        test_drop();
        test_reset_mid();
        test_idle_done();
        test_timeout();
        test_no_timeout();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb_4.md
Name: rr_arb_4

Overview:
- Four-requester round-robin arbiter that shares a single downstream resource.
- Grants exactly one requester at a time, presented as a 2-bit index plus its one-hot decode.
- Holds each grant until the owner releases it, drops its request, or hits a hold timeout.
- Sits in front of the shared resource; requesters see gnt, the resource sees gnt_id.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles per owner; 0 disables the timeout
CNT_W, 5, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request vector, bit n = requester n
done  input  1  owner releases the resource; sampled only while busy=1
gnt  output  4  one-hot grant, registered; all zero when idle
gnt_id  output  2  index of the current owner; valid only while busy=1
busy  output  1  a grant is active
timeout  output  1  one-cycle pulse on a forced release

Behaviour:
- All outputs are registered. Reset (rst=1 at a clk edge) sets gnt=0000, gnt_id=00, busy=0, timeout=0, ptr=00, hold_cnt=0, state=IDLE.
- Reset mid-grant drops the grant at that edge; no timeout pulse is generated.
- State IDLE:
  - If req!=0, pick the first set bit scanning circularly from ptr: ptr, ptr+1, ... mod 4.
  - At the next edge: busy=1, gnt_id=winner, gnt=onehot(winner), hold_cnt=1, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - done is ignored in IDLE.
- State GRANT, evaluated each edge with owner = gnt_id:
  - Release when done=1, or req[owner]=0.
  - Forced release when MAX_HOLD!=0 and hold_cnt==MAX_HOLD; timeout=1 for exactly the cycle following that edge.
  - If a normal and a forced release coincide, treat it as normal: timeout stays 0.
  - Otherwise hold, and hold_cnt increments with saturation at 2**CNT_W-1.
- On any release, at that edge:
  - busy=0, gnt=0000, hold_cnt=0, state=IDLE.
  - ptr=owner+1 mod 4, wrapping 3->0.
  - gnt_id keeps its last value; it is don't-care while busy=0.
- Mandatory turnaround: at least one idle cycle (gnt=0000) between consecutive grants, including regrant to the same requester.
- Fairness: with all four requests continuously asserted, grant order is 0,1,2,3,0,...; no requester waits more than 3 grant periods.
- Invariant: gnt is always either 0000 or one-hot and equal to decode(gnt_id); busy == |gnt.
- req changes on non-owner bits during GRANT have no effect on the current grant.

Decomposition:
- Package rr_arb_pkg holds:
  - typedef state_t {IDLE, GRANT}
  - localparam N_REQ=4
  - function next_ptr(id) = id+1 mod N_REQ
- Sub-module rr_pick: combinational circular priority picker; inputs req[3:0] and ptr[1:0]; outputs valid and win_id[1:0].
- gnt is produced by decoding the registered gnt_id with the team's existing 2-to-4 decoder deco_2x4, gated by busy.

Test Plan:
- Reset then req=0100 at cycle 2 -> gnt=0100, gnt_id=10, busy=1 at cycle 3; done pulse at cycle 6 -> gnt=0000 at cycle 7, ptr=11.
- req=1111 held, owner asserts done after 2 cycles each grant -> grant sequence 0001,0010,0100,1000,0001 with one 0000 cycle between grants.
- MAX_HOLD=4, req=0010 held, no done -> gnt=0010 for exactly 4 cycles, then gnt=0000 with timeout=1 for 1 cycle, then regrant 0010.
- Owner 1 drops req[1] while req=1001 pending -> release next edge, idle 1 cycle, then gnt=1000 (ptr=10 scans 2,3 before 0).
- rst=1 during GRANT with gnt=1000 -> next edge gnt=0000, busy=0, timeout=0; after rst deasserts with req=1001 -> gnt=0001 (ptr reset to 0).
- done=1 while idle with req=0000 -> no grant, all outputs stay 0; MAX_HOLD=0 with req held 40 cycles -> no timeout pulse, grant held throughout.
